// File: rtl/gerencia_pkg.sv
// Shared definitions for the HPS <-> coprocessor matrix manager: FSM state
// encoding and bit positions inside the 32-bit entrada/saida words.
package gerencia_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    COLLECT = 3'd3,
    SEND    = 3'd4
  } estado_t;

  // entrada word layout
  localparam int FLAG_HPS  = 0;
  localparam int OP_LSB    = 1;
  localparam int OP_W      = 3;
  localparam int DADOS_LSB = 4;
  localparam int ABORT     = 31;

  // saida word layout
  localparam int ACK   = 0;
  localparam int VALID = 30;
  localparam int LAST  = 31;

endpackage

// File: rtl/gerencia_matriz_envio_pacote.sv
// Packs the collected C matrix into PACK elements per word and hands the words
// to the HPS with a four-phase valid/read handshake.
module envio_pacote #(
  parameter int PACK  = 3,
  parameter int OUT_W = 9,
  parameter int NE    = 25
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ativo,
  input  logic                  limpar,
  input  logic [NE*OUT_W-1:0]   matriz_c,
  input  logic                  flag_lido,
  output logic [PACK*OUT_W-1:0] dados,
  output logic                  valido,
  output logic                  ultimo,
  output logic                  concluido
);

  localparam int NW = (NE + PACK - 1) / PACK;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LW = PACK * OUT_W;

  logic [WW-1:0]        palavra;
  logic                 espera;
  logic [NW-1:0][LW-1:0] palavras;

  // Zero-extension fills the unused slots of the final word with 0.
  assign palavras  = (NW*LW)'(matriz_c);
  assign dados     = palavras[palavra];
  assign valido    = ativo && !espera;
  assign ultimo    = ativo && (palavra == WW'(NW - 1));
  assign concluido = ativo && espera && !flag_lido && (palavra == WW'(NW - 1));

  // Four-phase sequencing: valid drops on read, word advances only once read falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      palavra <= '0;
      espera  <= 1'b0;
    end else if (limpar || !ativo) begin
      palavra <= '0;
      espera  <= 1'b0;
    end else if (!espera) begin
      if (flag_lido) espera <= 1'b1;
    end else if (!flag_lido) begin
      espera <= 1'b0;
      if (palavra == WW'(NW - 1)) palavra <= '0;
      else                        palavra <= palavra + 1'b1;
    end
  end

endmodule

// File: rtl/gerencia_matriz.sv
// Matrix manager: loads A/B element pairs from the HPS, starts the
// coprocessor, collects the C result and sends it back in packed words.
module gerencia_matriz
  import gerencia_pkg::*;
#(
  parameter int DIM   = 5,
  parameter int IN_W  = 8,
  parameter int OUT_W = 9,
  parameter int PACK  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            entrada,
  input  logic                   flag_lido,
  input  logic                   c_valido,
  input  logic [OUT_W-1:0]       entrada_matrizC,
  output logic [DIM*DIM*IN_W-1:0] matriz_a,
  output logic [DIM*DIM*IN_W-1:0] matriz_b,
  output logic [2:0]             opcode,
  output logic                   inicio,
  output logic [31:0]            saida
);

  localparam int NE = DIM * DIM;
  localparam int IW = $clog2(NE);
  localparam int CW = $clog2(NE + 1);

  estado_t              estado;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cidx;
  logic                 tomado;
  logic                 ack;
  logic [IN_W-1:0]      mem_a [NE];
  logic [IN_W-1:0]      mem_b [NE];
  logic [OUT_W-1:0]     mem_c [NE];
  logic [NE*OUT_W-1:0]  c_flat;

  logic                 flag_hps;
  logic                 abortar;
  logic [OP_W-1:0]      op_in;
  logic [IN_W-1:0]      a_in;
  logic [IN_W-1:0]      b_in;
  logic                 unused_bits;

  logic [PACK*OUT_W-1:0] dados;
  logic                  valido;
  logic                  ultimo;
  logic                  concluido;

  assign flag_hps    = entrada[FLAG_HPS];
  assign abortar     = entrada[ABORT];
  assign op_in       = entrada[OP_LSB +: OP_W];
  assign a_in        = entrada[DADOS_LSB +: IN_W];
  assign b_in        = entrada[DADOS_LSB + IN_W +: IN_W];
  assign unused_bits = ^entrada[ABORT-1:DADOS_LSB + 2*IN_W];

  for (genvar g = 0; g < NE; g++) begin : g_flat
    assign matriz_a[g*IN_W +: IN_W]   = mem_a[g];
    assign matriz_b[g*IN_W +: IN_W]   = mem_b[g];
    assign c_flat[g*OUT_W +: OUT_W]   = mem_c[g];
  end

  // Control FSM: load handshake, start pulse, result collection, abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado <= IDLE;
      idx    <= '0;
      cidx   <= '0;
      tomado <= 1'b0;
      ack    <= 1'b0;
      inicio <= 1'b0;
      opcode <= '0;
      for (int i = 0; i < NE; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      inicio <= 1'b0;
      if (estado != IDLE && abortar) begin
        estado <= IDLE;
        idx    <= '0;
        cidx   <= '0;
        tomado <= 1'b0;
        ack    <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            idx    <= '0;
            cidx   <= '0;
            tomado <= 1'b0;
            ack    <= 1'b0;
            if (flag_hps) estado <= LOAD;
          end
          LOAD: begin
            if (flag_hps) begin
              if (!tomado) begin
                mem_a[idx] <= a_in;
                mem_b[idx] <= b_in;
                opcode     <= op_in;
                ack        <= 1'b1;
                tomado     <= 1'b1;
              end
            end else if (tomado) begin
              ack    <= 1'b0;
              tomado <= 1'b0;
              if (idx == IW'(NE - 1)) begin
                idx    <= '0;
                estado <= START;
                inicio <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          START: estado <= COLLECT;
          COLLECT: begin
            if (c_valido && cidx < CW'(NE)) begin
              cidx <= cidx + 1'b1;
              if (cidx == CW'(NE - 1)) estado <= SEND;
            end
          end
          SEND: begin
            if (concluido) begin
              estado <= IDLE;
              cidx   <= '0;
            end
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

  // Result storage; contents are don't-care until fully collected.
  always_ff @(posedge clk) begin
    if (estado == COLLECT && !abortar && c_valido && cidx < CW'(NE))
      mem_c[cidx[IW-1:0]] <= entrada_matrizC;
  end

  envio_pacote #(
    .PACK  (PACK),
    .OUT_W (OUT_W),
    .NE    (NE)
  ) u_envio (
    .clk       (clk),
    .reset_n   (reset_n),
    .ativo     (estado == SEND),
    .limpar    (abortar),
    .matriz_c  (c_flat),
    .flag_lido (flag_lido),
    .dados     (dados),
    .valido    (valido),
    .ultimo    (ultimo),
    .concluido (concluido)
  );

  // Output word assembly: load ack outside SEND, packed C data inside SEND.
  always_comb begin
    saida      = '0;
    saida[ACK] = ack;
    if (estado == SEND) begin
      saida[PACK*OUT_W-1:0] = dados;
      saida[VALID]          = valido;
      saida[LAST]           = ultimo;
    end
  end

endmodule

// File: tb/tb_gerencia_matriz.sv
// Bench for gerencia_matriz: a DIM=5/PACK=3 instance and a DIM=2/PACK=2 instance
// driven through load, start, collect and packed send, plus abort and reset.
module tb_gerencia_matriz;

  localparam int IN_W = 8;
  localparam int OUT_W = 9;
  localparam int NE5 = 25, NW5 = 9, PK5 = 3;
  localparam int NE2 = 4,  NW2 = 2, PK2 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] ent5, ent2, sd5, sd2;
  logic lido5, lido2, cv5, cv2, ini5, ini2;
  logic [OUT_W-1:0] cin5, cin2;
  logic [NE5*IN_W-1:0] ma5, mb5;
  logic [NE2*IN_W-1:0] ma2, mb2;
  logic [2:0] op5, op2;

  int n_cmp = 0;
  int n_err = 0;
  int ref_a[NE5], ref_b[NE5], ref_c[NE5];
  int ref_op;

  always #5 clk = ~clk;

  gerencia_matriz #(.DIM(5), .IN_W(IN_W), .OUT_W(OUT_W), .PACK(PK5)) u5 (
    .clk(clk), .reset_n(reset_n), .entrada(ent5), .flag_lido(lido5),
    .c_valido(cv5), .entrada_matrizC(cin5), .matriz_a(ma5), .matriz_b(mb5),
    .opcode(op5), .inicio(ini5), .saida(sd5));

  gerencia_matriz #(.DIM(2), .IN_W(IN_W), .OUT_W(OUT_W), .PACK(PK2)) u2 (
    .clk(clk), .reset_n(reset_n), .entrada(ent2), .flag_lido(lido2),
    .c_valido(cv2), .entrada_matrizC(cin2), .matriz_a(ma2), .matriz_b(mb2),
    .opcode(op2), .inicio(ini2), .saida(sd2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sai(input bit s);
    return s ? sd2 : sd5;
  endfunction

  task automatic set_ent(input bit s, input logic [31:0] w);
    if (s) ent2 = w; else ent5 = w;
  endtask

  // One HPS element transfer: raise flag, wait for ack, optionally hold, drop, wait ack low.
  task automatic load_elem(input bit s, input int a, input int b, input int op, input int hold);
    logic [31:0] w, v;
    int t;
    w = '0;
    w[0] = 1'b1;
    w[3:1] = op[2:0];
    w[4 +: IN_W] = a[IN_W-1:0];
    w[4+IN_W +: IN_W] = b[IN_W-1:0];
    set_ent(s, w);
    t = 0; v = sai(s);
    while (v[0] !== 1'b1 && t < 20) begin tick(); t++; v = sai(s); end
    check("ack_set", {63'd0, v[0]}, 64'd1);
    for (int k = 0; k < hold; k++) begin
      tick(); v = sai(s);
      check("ack_hold", {63'd0, v[0]}, 64'd1);
    end
    w[0] = 1'b0;
    set_ent(s, w);
    t = 0; v = sai(s);
    while (v[0] !== 1'b0 && t < 20) begin tick(); t++; v = sai(s); end
    check("ack_clr", {63'd0, v[0]}, 64'd0);
  endtask

  // Start pulse must already be high and stay high exactly one cycle in total.
  task automatic count_inicio(input bit s);
    int c;
    c = s ? int'(ini2) : int'(ini5);
    check("inicio_now", 64'(c), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      c += s ? int'(ini2) : int'(ini5);
    end
    check("inicio_pulses", 64'(c), 64'd1);
  endtask

  // Feed ref_c with random gaps, then keep c_valido asserted with junk data.
  task automatic feed_c(input bit s, input int n);
    int i;
    bit g;
    logic [OUT_W-1:0] d;
    i = 0;
    while (i < n) begin
      g = ($urandom_range(0, 2) != 0);
      d = g ? ref_c[i][OUT_W-1:0] : OUT_W'($urandom);
      if (s) begin cv2 = g; cin2 = d; end else begin cv5 = g; cin5 = d; end
      tick();
      if (g) i++;
    end
    for (int k = 0; k < 3; k++) begin
      d = OUT_W'($urandom);
      if (s) begin cv2 = 1'b1; cin2 = d; end else begin cv5 = 1'b1; cin5 = d; end
      tick();
    end
    cv2 = 1'b0;
    cv5 = 1'b0;
  endtask

  function automatic logic [63:0] exp_word(input int w, input int pk, input int ne);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < pk; k++)
      if (w*pk + k < ne) e = e | (64'(ref_c[w*pk + k]) << (k*OUT_W));
    return e;
  endfunction

  // Receive and check one packed word; hold10 keeps flag_lido high 10 cycles.
  task automatic recv_word(input bit s, input int w, input int nw, input int pk, input int ne, input bit hold10);
    logic [31:0] v;
    int t, vc;
    t = 0; v = sai(s);
    while (v[30] !== 1'b1 && t < 20) begin tick(); t++; v = sai(s); end
    check($sformatf("valid_w%0d", w), {63'd0, v[30]}, 64'd1);
    check($sformatf("data_w%0d", w), {34'd0, v[29:0]}, exp_word(w, pk, ne));
    check($sformatf("last_w%0d", w), {63'd0, v[31]}, {63'd0, (w == nw-1)});
    if (s) lido2 = 1'b1; else lido5 = 1'b1;
    if (hold10) begin
      vc = 0;
      for (int k = 0; k < 10; k++) begin
        tick(); v = sai(s);
        if (v[30] === 1'b1) vc++;
      end
      check("hold_valid_cycles", 64'(vc), 64'd0);
    end else begin
      t = 0;
      do begin tick(); t++; v = sai(s); end while (v[30] !== 1'b0 && t < 20);
      check($sformatf("valid_drop_w%0d", w), {63'd0, v[30]}, 64'd0);
    end
    if (s) lido2 = 1'b0; else lido5 = 1'b0;
    tick();
  endtask

  task automatic check_operands5();
    for (int i = 0; i < NE5; i++) begin
      check($sformatf("ma5[%0d]", i), 64'(ma5[i*IN_W +: IN_W]), 64'(ref_a[i]));
      check($sformatf("mb5[%0d]", i), 64'(mb5[i*IN_W +: IN_W]), 64'(ref_b[i]));
    end
    check("opcode5", 64'(op5), 64'(ref_op));
  endtask

  initial begin
    int na, nb;
    logic [31:0] v;
    int t;
    ent5 = '0; ent2 = '0; lido5 = 1'b0; lido2 = 1'b0;
    cv5 = 1'b0; cv2 = 1'b0; cin5 = '0; cin2 = '0;

    // Reset state
    repeat (3) tick();
    check("rst_saida5", 64'(sd5), 64'd0);
    check("rst_saida2", 64'(sd2), 64'd0);
    check("rst_inicio5", 64'(ini5), 64'd0);
    check("rst_opcode5", 64'(op5), 64'd0);
    check("rst_ma5", 64'(|ma5), 64'd0);
    check("rst_mb5", 64'(|mb5), 64'd0);
    reset_n = 1'b1;
    tick();

    // Directed load A[i]=i, B[i]=2i, op=3; C[i]=300+i; long read hold on word 0
    ref_op = 3;
    for (int i = 0; i < NE5; i++) begin ref_a[i] = i; ref_b[i] = 2*i; ref_c[i] = 300 + i; end
    for (int i = 0; i < NE5; i++) load_elem(1'b0, ref_a[i], ref_b[i], ref_op, (i == 4) ? 3 : 0);
    count_inicio(1'b0);
    check_operands5();
    feed_c(1'b0, NE5);
    for (int w = 0; w < NW5; w++) recv_word(1'b0, w, NW5, PK5, NE5, (w == 0));
    tick();
    check("idle_after_send5", 64'(sd5), 64'd0);

    // Abort after element 10, then a fresh load must land at index 0
    for (int i = 0; i <= 10; i++) begin
      ref_a[i] = $urandom_range(0, 255); ref_b[i] = $urandom_range(0, 255);
      load_elem(1'b0, ref_a[i], ref_b[i], 5, 0);
    end
    ent5 = 32'h8000_0000;
    tick();
    check("abort_saida", 64'(sd5), 64'd0);
    ent5 = '0;
    tick();
    na = $urandom_range(0, 255); nb = $urandom_range(0, 255);
    load_elem(1'b0, na, nb, 6, 0);
    ref_a[0] = na; ref_b[0] = nb;
    check("abort_reload_a0", 64'(ma5[0 +: IN_W]), 64'(na));
    check("abort_reload_b0", 64'(mb5[0 +: IN_W]), 64'(nb));
    check("abort_keep_a1", 64'(ma5[1*IN_W +: IN_W]), 64'(ref_a[1]));
    check("abort_keep_a11", 64'(ma5[11*IN_W +: IN_W]), 64'(ref_a[11]));
    ent5 = 32'h8000_0000;
    tick();
    check("abort2_saida", 64'(sd5), 64'd0);
    check("abort2_inicio", 64'(ini5), 64'd0);
    ent5 = '0;
    tick();

    // Random full transaction
    ref_op = $urandom_range(0, 7);
    for (int i = 0; i < NE5; i++) begin
      ref_a[i] = $urandom_range(0, 255);
      ref_b[i] = $urandom_range(0, 255);
      ref_c[i] = $urandom_range(0, 511);
    end
    for (int i = 0; i < NE5; i++) load_elem(1'b0, ref_a[i], ref_b[i], ref_op, $urandom_range(0, 2));
    count_inicio(1'b0);
    check_operands5();
    feed_c(1'b0, NE5);
    for (int w = 0; w < NW5; w++) recv_word(1'b0, w, NW5, PK5, NE5, 1'b0);
    tick();
    check("idle_after_rand5", 64'(sd5), 64'd0);

    // DIM=2, PACK=2: C={5,6,7,8}
    for (int i = 0; i < NE2; i++) begin
      ref_a[i] = $urandom_range(0, 255); ref_b[i] = $urandom_range(0, 255);
      load_elem(1'b1, ref_a[i], ref_b[i], 1, 0);
    end
    count_inicio(1'b1);
    for (int i = 0; i < NE2; i++)
      check($sformatf("ma2[%0d]", i), 64'(ma2[i*IN_W +: IN_W]), 64'(ref_a[i]));
    check("opcode2", 64'(op2), 64'd1);
    for (int i = 0; i < NE2; i++) ref_c[i] = 5 + i;
    feed_c(1'b1, NE2);
    for (int w = 0; w < NW2; w++) recv_word(1'b1, w, NW2, PK2, NE2, 1'b0);
    tick();
    check("idle_after_send2", 64'(sd2), 64'd0);

    // Reset asserted during SEND clears outputs without waiting for a clock edge
    for (int i = 0; i < NE2; i++) load_elem(1'b1, 10 + i, 20 + i, 2, 0);
    count_inicio(1'b1);
    feed_c(1'b1, NE2);
    t = 0; v = sd2;
    while (v[30] !== 1'b1 && t < 20) begin tick(); t++; v = sd2; end
    check("send2_valid_before_rst", {63'd0, v[30]}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_saida2", 64'(sd2), 64'd0);
    check("rst_async_opcode2", 64'(op2), 64'd0);
    check("rst_async_ma2", 64'(|ma2), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    na = $urandom_range(1, 255);
    load_elem(1'b1, na, 7, 4, 0);
    check("post_rst_a0", 64'(ma2[0 +: IN_W]), 64'(na));
    check("post_rst_a1", 64'(ma2[1*IN_W +: IN_W]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
